// File: rtl/fp_conv_arbiter.sv
// Round-robin arbiter that shares one combinational 12-bit fixed-to-float converter among NUM_REQ requesters.
// Optional macro FP_CONV_ARB_PIPE_EN lets a new grant happen in the same cycle that a response is accepted.
module fp_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [12*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [11:0]           conv_D,
  input  logic                  conv_S,
  input  logic [2:0]            conv_E,
  input  logic [3:0]            conv_F,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic                  resp_S,
  output logic [2:0]            resp_E,
  output logic [3:0]            resp_F
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, grant_id_q;
  logic [ID_W-1:0] winner, rr_next;
  logic [11:0]     operand_q, win_data;
  logic            any_valid, grant_en;

  // Rotating priority search starting at rr_ptr; the wrap is an explicit
  // compare so non-power-of-two NUM_REQ never yields an id >= NUM_REQ.
  always_comb begin
    logic [ID_W:0] idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!any_valid && req_valid[idx[ID_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) win_data = req_data[12*i +: 12];
    end
  end

  assign rr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

`ifdef FP_CONV_ARB_PIPE_EN
  assign grant_en = !rst && any_valid &&
                    ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
`else
  assign grant_en = !rst && any_valid && (state_q == IDLE);
`endif

  always_comb begin
    req_ready = '0;
    if (grant_en) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_en) state_d = CONV;
      CONV:    state_d = RESP;
      RESP:    if (resp_ready) state_d = grant_en ? CONV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      operand_q  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_S     <= 1'b0;
      resp_E     <= '0;
      resp_F     <= '0;
    end else begin
      if (grant_en) begin
        operand_q  <= win_data;
        grant_id_q <= winner;
        rr_ptr_q   <= rr_next;
      end
      if (state_q == CONV) begin
        resp_S     <= conv_S;
        resp_E     <= conv_E;
        resp_F     <= conv_F;
        resp_id    <= grant_id_q;
        resp_valid <= 1'b1;
      end else if ((state_q == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // Converter input comes straight from a register, so it cannot glitch with req_data.
  assign conv_D = operand_q;

endmodule

// File: tb/tb_fp_conv_arbiter.sv
// Directed self-checking bench for fp_conv_arbiter (default build) with a behavioural converter model.
module tb_fp_conv_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [12*N-1:0] req_data;
  logic [11:0]     conv_D;
  logic            conv_S;
  logic [2:0]      conv_E;
  logic [3:0]      conv_F;
  logic            resp_valid, resp_ready;
  logic [IW-1:0]   resp_id;
  logic            resp_S;
  logic [2:0]      resp_E;
  logic [3:0]      resp_F;

  int total = 0;
  int bad   = 0;
  logic [11:0] dv [N];

  fp_conv_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .conv_D(conv_D), .conv_S(conv_S), .conv_E(conv_E), .conv_F(conv_F),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_S(resp_S), .resp_E(resp_E), .resp_F(resp_F)
  );

  always #5 clk = ~clk;

  // Converter model: sign, exponent = position of leading one minus 3, top four bits; -2048 saturates.
  function automatic logic [7:0] conv_model(input logic [11:0] d);
    logic        s;
    logic [11:0] mag;
    logic [2:0]  e;
    logic [3:0]  f;
    int          p;
    s   = d[11];
    mag = s ? (~d + 12'd1) : d;
    if (d == 12'h800) return 8'hFF;
    p = -1;
    for (int b = 0; b < 12; b++) if (mag[b]) p = b;
    if (p <= 3) begin
      e = 3'd0;
      f = mag[3:0];
    end else begin
      e = 3'(p - 3);
      f = 4'(mag >> (p - 3));
    end
    return {s, e, f};
  endfunction

  assign {conv_S, conv_E, conv_F} = conv_model(conv_D);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, input logic [N-1:0] exp);
    for (int c = 0; c < 6 && req_ready == '0; c++) tick();
    check(tag, 32'(req_ready), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dv[0] = 12'h001;
    dv[1] = 12'h800;
    dv[2] = 12'h000;
    dv[3] = 12'hF5B;
    for (int i = 0; i < N; i++) req_data[12*i +: 12] = dv[i];
    rst = 1'b1; req_valid = 4'b1111; resp_ready = 1'b0;

    // Reset held for two edges with every requester asking
    tick(); tick();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_conv_D", 32'(conv_D), 0);
    check("rst_resp_fields", 32'({resp_id, resp_S, resp_E, resp_F}), 0);
    rst = 1'b0; #1;
    check("rst_first_grant", 32'(req_ready), 32'(4'b0001));
    tick(); req_valid = '0; #1;
    check("rst_first_conv_D", 32'(conv_D), 32'(12'h001));
    tick();
    check("rst_first_resp_id", 32'(resp_id), 0);
    resp_ready = 1'b1; tick();

    // Single request from requester 2, zero operand
    req_valid = 4'b0100; #1;
    check("single_req_ready", 32'(req_ready), 32'(4'b0100));
    tick(); req_valid = '0; #1;
    check("single_conv_ready", 32'(req_ready), 0);
    check("single_conv_valid", 32'(resp_valid), 0);
    check("single_conv_D", 32'(conv_D), 32'(12'h000));
    tick();
    check("single_resp_valid", 32'(resp_valid), 1);
    check("single_resp_id", 32'(resp_id), 2);
    check("single_resp_sef", 32'({resp_S, resp_E, resp_F}), 32'(8'h00));
    tick();
    check("single_idle_valid", 32'(resp_valid), 0);

    // Saturating operand from requester 1
    req_valid = 4'b0010; #1;
    check("sat_req_ready", 32'(req_ready), 32'(4'b0010));
    tick(); req_valid = '0; #1;
    check("sat_conv_D", 32'(conv_D), 32'(12'h800));
    tick();
    check("sat_resp_id", 32'(resp_id), 1);
    check("sat_resp_sef", 32'({resp_S, resp_E, resp_F}), 32'(8'hFF));
    tick();

    // Round-robin with all requesters continuously valid, after a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b1111; resp_ready = 1'b1; #1;
    for (int g = 0; g < 5; g++) begin
      int e;
      e = g % N;
      wait_grant("rr_grant", N'(1 << e));
      tick();
      check("rr_conv_D", 32'(conv_D), 32'(dv[e]));
      tick();
      check("rr_resp_valid", 32'(resp_valid), 1);
      check("rr_resp_id", 32'(resp_id), 32'(e));
      check("rr_resp_sef", 32'({resp_S, resp_E, resp_F}), 32'(conv_model(dv[e])));
    end
    req_valid = '0; tick();

    // Backpressure: rr_ptr is 1, requester 3 alone wins, then 5 stalled cycles
    resp_ready = 1'b0; req_valid = 4'b1000; #1;
    check("bp_req_ready", 32'(req_ready), 32'(4'b1000));
    tick(); req_valid = 4'b0011; #1;
    check("bp_conv_ready", 32'(req_ready), 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_resp_valid", 32'(resp_valid), 1);
      check("bp_resp_id", 32'(resp_id), 3);
      check("bp_resp_sef", 32'({resp_S, resp_E, resp_F}), 32'(8'hCA));
      check("bp_req_ready_hold", 32'(req_ready), 0);
      check("bp_conv_D", 32'(conv_D), 32'(12'hF5B));
      tick();
    end
    resp_ready = 1'b1; #1;
    tick();
    check("bp_after_valid", 32'(resp_valid), 0);
    check("bp_next_grant", 32'(req_ready), 32'(4'b0001));

    // Reset during CONV with requester 3 pending: in-flight data discarded, rr_ptr back to 0
    tick(); req_valid = 4'b1001; rst = 1'b1; #1;
    tick();
    check("midrst_resp_valid", 32'(resp_valid), 0);
    check("midrst_req_ready", 32'(req_ready), 0);
    check("midrst_conv_D", 32'(conv_D), 0);
    tick();
    check("midrst_resp_valid2", 32'(resp_valid), 0);
    rst = 1'b0; #1;
    check("midrst_grant_order", 32'(req_ready), 32'(4'b0001));
    tick(); req_valid = 4'b1000; #1;
    check("midrst_conv_D_after", 32'(conv_D), 32'(12'h001));
    tick();
    check("midrst_resp_id0", 32'(resp_id), 0);
    tick();
    check("midrst_req3_grant", 32'(req_ready), 32'(4'b1000));
    tick(); req_valid = '0; #1;
    tick();
    check("midrst_resp_id3", 32'(resp_id), 3);
    check("midrst_resp_sef3", 32'({resp_S, resp_E, resp_F}), 32'(8'hCA));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_conv_arbiter.md
Name: fp_conv_arbiter

Overview:
- Shares one combinational 12-bit-to-floating-point converter (D -> S, E[2:0], F[3:0]) among NUM_REQ requesters.
- Requests are granted round-robin. The winning operand is registered and driven onto the converter.
- The converter result is captured into a response register and held under a valid/ready handshake, tagged with the requester id.
- Sits between sample producers and the single converter instance in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  12*NUM_REQ  per-requester two's-complement operand; requester i occupies bits [12i+11:12i].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- conv_D  out  12  operand driven to the shared converter.
- conv_S  in  1  converter sign result.
- conv_E  in  3  converter exponent result.
- conv_F  in  4  converter significand result.
- resp_valid  out  1  response held valid.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  ID_W  requester index of the response.
- resp_S  out  1  captured sign.
- resp_E  out  3  captured exponent.
- resp_F  out  4  captured significand.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rr_ptr=0, operand register=0 (so conv_D=0), resp_valid=0, resp_id=0, resp_S/E/F=0, req_ready=0. Reset wins over every other event, including mid-conversion or mid-response; in-flight data is discarded.
- FSM states: IDLE, CONV, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the winner only when state==IDLE and at least one req_valid is high; otherwise all zero.
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On that edge: operand <= req_data[winner]; grant_id <= winner; rr_ptr <= (winner+1) mod NUM_REQ; state <= CONV.
  - With no valid request, all state holds.
- CONV:
  - conv_D = operand register for the whole cycle.
  - On the edge: resp_S/E/F <= conv_S/E/F; resp_id <= grant_id; resp_valid <= 1; state <= RESP.
  - Fixed one-cycle converter latency; req_ready=0.
- RESP:
  - resp_valid=1; resp_* stable until accepted.
  - When resp_valid && resp_ready: resp_valid <= 0, state <= IDLE.
  - req_ready=0 throughout.
- conv_D always reflects the operand register; it changes only on a grant, never glitches with req_data.
- Throughput without the optional feature: one conversion per 3 cycles minimum.
- Latency: grant edge -> resp_valid high 1 cycle later.
- Requester protocol: a requester must hold req_valid and req_data stable until it sees req_ready. Dropping req_valid before acceptance is allowed; that request is simply not granted.
- rr_ptr advances only on a grant, so a sole continuous requester is granted every opportunity.
- NUM_REQ not a power of two: wrap uses an explicit modulo compare. Ids >= NUM_REQ are never produced.

Optional Feature:
- Macro: FP_CONV_ARB_PIPE_EN.
- Defined: in RESP, when resp_ready=1 and any req_valid=1, the arbiter grants in the same cycle.
  - req_ready is asserted for the winner in RESP under that condition.
  - Operand, grant_id and rr_ptr update as in IDLE; state goes RESP -> CONV directly, skipping IDLE.
  - Throughput becomes one conversion per 2 cycles.
- Undefined: RESP always returns to IDLE; req_ready is never asserted outside IDLE.

Test Plan:
- Reset: hold rst 2 cycles with req_valid=4'b1111 -> req_ready=0, resp_valid=0, conv_D=12'h000, resp_* = 0; first grant after release goes to requester 0.
- Single request: req 2 asserts D=12'h000, resp_ready=1 -> req_ready=4'b0100 in cycle t; resp_valid in t+2 with resp_id=2, S=0, E=0, F=0; back to IDLE at t+3.
- Saturation passthrough: req 1 asserts D=12'h800 -> conv_D=12'h800 during CONV; resp_id=1, S=1, E=7, F=15 (matches the converter model).
- Round-robin: all four valid continuously, resp_ready=1 -> grant order 0,1,2,3,0; each resp_id matches; no requester starved.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready=0, conv_D unchanged; with resp_ready=1, one response handshake occurs, then the next grant.
- Reset mid-operation: assert rst during CONV with req 3 pending -> resp_valid never rises; after release req 3 is granted with rr_ptr=0 order. With FP_CONV_ARB_PIPE_EN defined, back-to-back requests give resp_valid on every second cycle.
